// File: rtl/fir_coeff_loader.sv
// FIR coefficient-RAM update initiator: burst-writes a host-filled shadow file into the filter RAM.
// Optional macro FIR_COEFF_READBACK_EN adds a read-back/compare pass with done/error reporting.
module fir_coeff_loader #(
  parameter int unsigned NUM_TAPS  = 33,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_BASE = 1,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iHostWr,
  input  logic [ADDR_W-1:0] iHostAddr,
  input  logic [DATA_W-1:0] iHostData,
  input  logic              iStart,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  input  logic [DATA_W-1:0] iRdDtRam,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic [ADDR_W-1:0] oErrAddr
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(ADDR_BASE);

  generate
    if (NUM_TAPS + ADDR_BASE > (2 ** ADDR_W)) begin : g_bad_addr_cfg
      $error("fir_coeff_loader: NUM_TAPS + ADDR_BASE exceeds RAM address space");
    end
    if (RD_LAT < 1) begin : g_bad_lat_cfg
      $error("fir_coeff_loader: RD_LAT must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] tap;
  logic [ADDR_W-1:0] tap_nxt;
  logic [DATA_W-1:0] shadow [NUM_TAPS];

  assign tap_nxt = tap + ADDR_W'(1);

  // Host shadow file; frozen while a transfer is in flight.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NUM_TAPS; i++) shadow[i] <= '0;
    end else if (iHostWr && !oBusy && (iHostAddr <= LAST_TAP)) begin
      shadow[iHostAddr] <= iHostData;
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [CNT_W-1:0]  drain_cnt;
  logic [RD_LAT-1:0] pipe_vld;
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic [ADDR_W-1:0] cmp_addr;
  logic [ADDR_W-1:0] cmp_tap;

  assign cmp_addr = pipe_addr[RD_LAT-1];
  assign cmp_tap  = cmp_addr - BASE;

  // Tracks each read address until its data returns RD_LAT cycles later.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= !oCsnRam && oWrnRam;
      pipe_addr[0] <= oAddrRam;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^iRdDtRam;
  assign oErr      = 1'b0;
  assign oErrAddr  = '0;
`endif

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state             <= IDLE;
      tap               <= '0;
      oCoeffiUpdateFlag <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= '0;
      oWrDtRam          <= '0;
      oBusy             <= 1'b0;
      oDone             <= 1'b0;
`ifdef FIR_COEFF_READBACK_EN
      drain_cnt         <= '0;
      oErr              <= 1'b0;
      oErrAddr          <= '0;
`endif
    end else begin
      oDone <= 1'b0;
`ifdef FIR_COEFF_READBACK_EN
      // Only the first mismatch of a transfer is recorded.
      if (pipe_vld[RD_LAT-1] && !oErr && (iRdDtRam != shadow[cmp_tap])) begin
        oErr     <= 1'b1;
        oErrAddr <= cmp_addr;
      end
`endif
      case (state)
        IDLE: begin
          if (iStart) begin
            state             <= WRITE;
            tap               <= '0;
            oBusy             <= 1'b1;
            oCoeffiUpdateFlag <= 1'b1;
            oCsnRam           <= 1'b0;
            oWrnRam           <= 1'b0;
            oAddrRam          <= BASE;
            oWrDtRam          <= shadow[0];
`ifdef FIR_COEFF_READBACK_EN
            oErr              <= 1'b0;
            oErrAddr          <= '0;
`endif
          end
        end
        WRITE: begin
          if (tap == LAST_TAP) begin
            tap               <= '0;
            oCoeffiUpdateFlag <= 1'b0;
            oWrDtRam          <= '0;
            oWrnRam           <= 1'b1;
`ifdef FIR_COEFF_READBACK_EN
            state             <= READ;
            oCsnRam           <= 1'b0;
            oAddrRam          <= BASE;
`else
            state             <= DONE;
            oCsnRam           <= 1'b1;
            oAddrRam          <= '0;
            oBusy             <= 1'b0;
            oDone             <= 1'b1;
`endif
          end else begin
            tap      <= tap_nxt;
            oAddrRam <= BASE + tap_nxt;
            oWrDtRam <= shadow[tap_nxt];
          end
        end
`ifdef FIR_COEFF_READBACK_EN
        READ: begin
          if (tap == LAST_TAP) begin
            state     <= DRAIN;
            tap       <= '0;
            drain_cnt <= '0;
            oCsnRam   <= 1'b1;
            oAddrRam  <= '0;
          end else begin
            tap      <= tap_nxt;
            oAddrRam <= BASE + tap_nxt;
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_W'(RD_LAT - 1)) begin
            state <= DONE;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: behavioural RAM + shadow model, randomized loads,
// cycle-by-cycle bus expectations, readback-corruption and ignored-input scenarios.
module tb_fir_coeff_loader;

  localparam int N       = 33;
  localparam int AW      = 6;
  localparam int DW      = 16;
  localparam int BASE    = 1;
  localparam int RD_LAT  = 1;
`ifdef FIR_COEFF_READBACK_EN
  localparam int DONE_CYC = 2 * N + RD_LAT + 1;
  localparam bit RB       = 1'b1;
`else
  localparam int DONE_CYC = N + 1;
  localparam bit RB       = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          start;
  logic          flag, csn, wrn, busy, done, err;
  logic [AW-1:0] addr, err_addr;
  logic [DW-1:0] wrdt, rddt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_shadow [N];
  logic [DW-1:0] ram   [2**AW];
  logic [DW-1:0] cmask [2**AW];
  logic [DW-1:0] cap17;

  always #5 clk = ~clk;

  fir_coeff_loader #(
    .NUM_TAPS(N), .ADDR_W(AW), .DATA_W(DW), .ADDR_BASE(BASE), .RD_LAT(RD_LAT)
  ) dut (
    .iClk_12M(clk), .iRst(rst), .iHostWr(host_wr), .iHostAddr(host_addr),
    .iHostData(host_data), .iStart(start), .oCoeffiUpdateFlag(flag),
    .oCsnRam(csn), .oWrnRam(wrn), .oAddrRam(addr), .oWrDtRam(wrdt),
    .iRdDtRam(rddt), .oBusy(busy), .oDone(done), .oErr(err), .oErrAddr(err_addr)
  );

  // One-cycle-latency RAM with a per-address read corruption mask.
  always @(posedge clk) begin
    if (!csn && !wrn) ram[addr] <= wrdt;
    rddt <= ram[addr] ^ cmask[addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lp_coef(input int i);
    int j = (i > 16) ? 32 - i : i;
    case (j)
      0: return 16'h0003;   1: return 16'h0000;   2: return 16'hFFFA;
      3: return 16'hFFF5;   4: return 16'h0000;   5: return 16'h0012;
      6: return 16'h001C;   7: return 16'h0000;   8: return 16'hFFD0;
      9: return 16'hFFB8;  10: return 16'h0000;  11: return 16'h0070;
      12: return 16'h00A0; 13: return 16'h0030;  14: return 16'h0090;
      15: return 16'h0140; default: return 16'h01F4;
    endcase
  endfunction

  // Expected bus {flag,csn,wrn,busy,done,addr,wrdt} for cycle n after the start edge.
  function automatic logic [63:0] exp_bus(input int n);
    logic f = 1'b0, c = 1'b1, w = 1'b1, b = 1'b0, d = 1'b0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] wd = '0;
    if (n >= 1 && n <= N) begin
      f = 1'b1; c = 1'b0; w = 1'b0; b = 1'b1;
      a = AW'(BASE + n - 1); wd = m_shadow[n-1];
    end
`ifdef FIR_COEFF_READBACK_EN
    else if (n <= 2 * N) begin
      c = 1'b0; b = 1'b1; a = AW'(BASE + n - 1 - N);
    end
    else if (n < DONE_CYC) b = 1'b1;
`endif
    else if (n == DONE_CYC) d = 1'b1;
    return 64'({f, c, w, b, d, a, wd});
  endfunction

  task automatic host_write(input int idx, input logic [DW-1:0] data);
    host_wr = 1'b1; host_addr = AW'(idx); host_data = data;
    @(posedge clk); #1;
    host_wr = 1'b0;
    if (idx < N) m_shadow[idx] = data;
  endtask

  task automatic run_xfer(input bit disturb);
    logic          exp_err = 1'b0;
    logic [AW-1:0] exp_ea  = '0;
    if (RB) begin
      for (int k = 0; k < N; k++)
        if (!exp_err && cmask[BASE + k] != '0) begin
          exp_err = 1'b1; exp_ea = AW'(BASE + k);
        end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= DONE_CYC + 1; n++) begin
      if (disturb && n == 5) start = 1'b1;
      if (disturb && n == 10) begin
        host_wr = 1'b1; host_addr = AW'(3); host_data = ~m_shadow[3];
      end
      @(negedge clk);
      check($sformatf("bus@%0d", n), 64'({flag, csn, wrn, busy, done, addr, wrdt}), exp_bus(n));
      if (n <= N && addr == AW'(17)) cap17 = wrdt;
      if (n == 1) check("err_cleared", 64'({err, err_addr}), 64'(0));
      if (n == DONE_CYC) check("err_result", 64'({err, err_addr}), 64'({exp_err, exp_ea}));
      @(posedge clk); #1;
      start = 1'b0; host_wr = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; host_wr = 1'b0; host_addr = '0; host_data = '0; start = 1'b0;
    cap17 = '0;
    for (int i = 0; i < 2**AW; i++) begin ram[i] = '0; cmask[i] = '0; end
    for (int i = 0; i < N; i++) m_shadow[i] = '0;
    #23;
    check("reset_bus", 64'({flag, csn, wrn, busy, done, addr, wrdt}), exp_bus(0));
    check("reset_err", 64'({err, err_addr}), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Lowpass load, including an out-of-range write that must be dropped.
    for (int i = 0; i < N; i++) host_write(i, lp_coef(i));
    host_write(40, 16'hDEAD);
    run_xfer(1'b0);
    check("wrdt_a17", 64'(cap17), 64'(16'h01F4));

    // Busy-time start and host write are ignored.
    run_xfer(1'b1);

    // Corrupted readback at addresses 20 and 25; shadow[3] must still be the original.
    cmask[20] = 16'h0001; cmask[25] = 16'h0100;
    run_xfer(1'b0);
    cmask[20] = '0; cmask[25] = '0;

    // Asynchronous reset in the middle of the write burst (beat 10).
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 11; n++) begin @(posedge clk); #1; end
    @(negedge clk);
    check("beat10_addr", 64'(addr), 64'(11));
    #1 rst = 1'b1;
    #1 check("midreset", 64'({flag, csn, wrn, busy, done}), 64'(5'b01100));
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) m_shadow[i] = '0;
    @(posedge clk); #1;
    run_xfer(1'b0);

    // Randomized loads, stray out-of-range writes and random corruption.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N; i++) host_write(i, DW'($urandom));
      for (int j = 0; j < 3; j++) host_write(int'($urandom_range(2**AW - 1, N)), DW'($urandom));
      if ($urandom_range(1, 0) == 1) cmask[BASE + int'($urandom_range(N - 1, 0))] = DW'($urandom_range(16'hFFFF, 1));
      run_xfer(it[0]);
      for (int i = 0; i < 2**AW; i++) cmask[i] = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
